aoi_pipe: RTL

- Parametrised, pipelined successor to the AOI22 cell.
- Computes an AND-OR-INVERT (or AND-OR when inversion is disabled) bitwise across WIDTH-bit vectors: GROUPS groups of TERMS terms each.
- Two-stage registered datapath with valid/ready handshake and a saturating completion counter.
- Used as a synthesisable logic-reduction macro in SoC flow test datapaths.

---
 rtl/aoi_pipe_if.sv | 41 ++++
 rtl/aoi_pipe.sv | 106 ++++++++++
 2 files changed

// File: rtl/aoi_pipe_if.sv
// ---------------------------------------------------------------------------
// aoi_pipe_if
// Handshake and data bundle for the aoi_pipe logic-reduction pipeline.
//
// Signals:
//   IN_VALID   master -> slave  operand valid
//   IN_READY   slave -> master  pipeline can take an operand this cycle
//   A          master -> slave  GROUPS*TERMS packed WIDTH-bit terms
//   INV        master -> slave  1 = AND-OR-INVERT, 0 = AND-OR
//   OUT_VALID  slave -> master  Y holds a result
//   OUT_READY  master -> slave  downstream consumes Y
//   Y          slave -> master  result vector
//   CNT        slave -> master  saturating count of completed transfers
// ---------------------------------------------------------------------------
interface aoi_pipe_if #(
  parameter int WIDTH  = 4,
  parameter int GROUPS = 2,
  parameter int TERMS  = 2,
  parameter int CNT_W  = 8
);
  logic                            IN_VALID;
  logic                            IN_READY;
  logic [GROUPS*TERMS*WIDTH-1:0]   A;
  logic                            INV;
  logic                            OUT_VALID;
  logic                            OUT_READY;
  logic [WIDTH-1:0]                Y;
  logic [CNT_W-1:0]                CNT;

  // The pipeline itself sits on the slave side
  modport slave (
    input  IN_VALID, A, INV, OUT_READY,
    output IN_READY, OUT_VALID, Y, CNT
  );

  // Whoever feeds operands and consumes results sits on the master side
  modport master (
    output IN_VALID, A, INV, OUT_READY,
    input  IN_READY, OUT_VALID, Y, CNT
  );
endinterface

// File: rtl/aoi_pipe.sv
// ---------------------------------------------------------------------------
// aoi_pipe
// Two-stage pipelined AND-OR(-INVERT) reduction, a parametrised successor
// of the AOI22 cell. Each group ANDs TERMS vectors, the GROUPS products are
// ORed, and the result is optionally inverted. Results leave through a
// valid/ready handshake; a saturating counter tracks completed transfers.
//
// Ports:
//   CLK  rising-edge clock
//   R    asynchronous active-low reset
//   bus  aoi_pipe_if slave modport (IN_VALID/IN_READY/A/INV in,
//        OUT_VALID/OUT_READY/Y out, CNT completion count)
// ---------------------------------------------------------------------------
module aoi_pipe #(
  parameter int WIDTH  = 4,
  parameter int GROUPS = 2,
  parameter int TERMS  = 2,
  parameter int CNT_W  = 8
) (
  input  logic      CLK,
  input  logic      R,
  aoi_pipe_if.slave bus
);

  logic [GROUPS*WIDTH-1:0] s1And_q, s1And_d;
  logic                    s1Inv_q;
  logic                    s1Valid_q, s1Valid_d;
  logic                    outValid_q, outValid_d;
  logic [WIDTH-1:0]        y_q, y_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]        orV;
  logic                    s2Free;
  logic                    inReady;
  logic                    accept;
  logic                    advance;

  // Stage 2 can take new data when empty or when its result leaves this
  // cycle; IN_READY is therefore combinational from OUT_READY.
  assign s2Free  = !outValid_q || bus.OUT_READY;
  assign inReady = !s1Valid_q || s2Free;
  assign accept  = bus.IN_VALID && inReady;
  assign advance = s1Valid_q && s2Free;

  // Stage 1 function: one AND product per group, taken straight off A
  always_comb begin
    s1And_d = '0;
    for (int g = 0; g < GROUPS; g++) begin
      s1And_d[g*WIDTH +: WIDTH] = '1;
      for (int t = 0; t < TERMS; t++) begin
        s1And_d[g*WIDTH +: WIDTH] = s1And_d[g*WIDTH +: WIDTH]
                                  & bus.A[(g*TERMS+t)*WIDTH +: WIDTH];
      end
    end
  end

  // Stage 2 function: OR the registered products, then apply the polarity
  // that travelled alongside them
  always_comb begin
    orV = '0;
    for (int g = 0; g < GROUPS; g++) begin
      orV = orV | s1And_q[g*WIDTH +: WIDTH];
    end
    y_d = s1Inv_q ? ~orV : orV;
  end

  // Next-state for the valid flags and the completion counter; the counter
  // sticks at all-ones instead of wrapping
  always_comb begin
    s1Valid_d  = accept ? 1'b1 : (advance ? 1'b0 : s1Valid_q);
    outValid_d = advance ? 1'b1 : (bus.OUT_READY ? 1'b0 : outValid_q);
    cnt_d      = cnt_q;
    if (outValid_q && bus.OUT_READY && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Pipeline registers; reset empties the pipe and clears every data
  // register so nothing stale or X can appear afterwards
  always_ff @(posedge CLK or negedge R) begin
    if (!R) begin
      s1And_q    <= '0;
      s1Inv_q    <= 1'b0;
      s1Valid_q  <= 1'b0;
      outValid_q <= 1'b0;
      y_q        <= '0;
      cnt_q      <= '0;
    end else begin
      s1Valid_q  <= s1Valid_d;
      outValid_q <= outValid_d;
      cnt_q      <= cnt_d;
      if (accept) begin
        s1And_q <= s1And_d;
        s1Inv_q <= bus.INV;
      end
      if (advance) begin
        y_q <= y_d;
      end
    end
  end

  assign bus.IN_READY  = inReady;
  assign bus.OUT_VALID = outValid_q;
  assign bus.Y         = y_q;
  assign bus.CNT       = cnt_q;

endmodule
